// File: rtl/fsm_timer_mealy.sv
// Loadable cycle timer with hold/abort control and a Mealy terminal pulse.
// One-shot mode returns to IDLE after the terminal cycle; auto-restart mode
// wraps the counter to zero and keeps running with the captured settings.
module fsm_timer_mealy #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [WIDTH-1:0] load,
  input  logic             mode,
  input  logic             hold,
  input  logic             abort,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             mode_q, mode_d;
  logic             at_term;

  // Terminal compare is an equality test, so a full-scale term never overflows.
  assign at_term = (count == term_q);

  // Mealy terminal pulse: suppressed by hold or abort in the same cycle.
  assign done = (state_q == RUN) && at_term && !hold && !abort;

  // Busy is a direct decode of the state register.
  assign busy = (state_q != IDLE);

  // State, counter and captured run settings.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count   <= '0;
      term_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      term_q  <= term_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state and counter update; abort outranks every other input.
  always_comb begin
    state_d = state_q;
    count_d = count;
    term_d  = term_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (go && !abort) begin
          term_d  = load;
          mode_d  = mode;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
        end else if (hold) begin
          state_d = PAUSE;
        end else if (at_term) begin
          count_d = '0;
          state_d = mode_q ? RUN : IDLE;
        end else begin
          count_d = count + WIDTH'(1);
        end
      end
      PAUSE: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
        end else if (!hold) begin
          state_d = RUN;
        end
      end
      default: begin
        // Unused encoding: fall back to a clean idle.
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fsm_timer_mealy.sv
// Bench for fsm_timer_mealy: an 8-bit and a 4-bit instance share control
// inputs and are compared every cycle against a behavioural timer model.
module tb_fsm_timer_mealy;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       go, mode, hold, abort;
  logic [7:0] load;
  logic       done8, busy8, done4, busy4;
  logic [7:0] count8;
  logic [3:0] count4;

  int checks = 0;
  int failures = 0;
  int busy_cnt8, done_cnt8, done_cnt4;

  // Behavioural model, index 0 = 8-bit instance, 1 = 4-bit instance.
  bit m_act[2];
  bit m_pause[2];
  bit m_mode[2];
  int m_cnt[2];
  int m_term[2];
  int m_span[2] = '{256, 16};

  always #5 clk = ~clk;

  fsm_timer_mealy #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .go(go), .load(load), .mode(mode),
    .hold(hold), .abort(abort), .done(done8), .busy(busy8), .count(count8)
  );

  fsm_timer_mealy #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .go(go), .load(load[3:0]), .mode(mode),
    .hold(hold), .abort(abort), .done(done4), .busy(busy4), .count(count4)
  );

  function automatic bit exp_done(int i);
    return m_act[i] && !m_pause[i] && (m_cnt[i] == m_term[i]) && !hold && !abort;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_pause[i] = 0; m_mode[i] = 0; m_cnt[i] = 0; m_term[i] = 0;
    end
  endtask

  // Apply the timer rules for one rising edge using the current inputs.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit d;
      d = exp_done(i);
      if (!m_act[i]) begin
        if (go && !abort) begin
          m_act[i] = 1; m_pause[i] = 0; m_cnt[i] = 0;
          m_term[i] = int'(load) % m_span[i];
          m_mode[i] = mode;
        end
      end else if (abort) begin
        m_act[i] = 0; m_pause[i] = 0; m_cnt[i] = 0;
      end else if (m_pause[i]) begin
        if (!hold) m_pause[i] = 0;
      end else if (hold) begin
        m_pause[i] = 1;
      end else if (d) begin
        m_cnt[i] = 0;
        if (!m_mode[i]) m_act[i] = 0;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endtask

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".count8"}, int'(count8), m_cnt[0]);
    chk({tag, ".busy8"},  int'(busy8),  int'(m_act[0]));
    chk({tag, ".done8"},  int'(done8),  int'(exp_done(0)));
    chk({tag, ".count4"}, int'(count4), m_cnt[1]);
    chk({tag, ".busy4"},  int'(busy4),  int'(m_act[1]));
    chk({tag, ".done4"},  int'(done4),  int'(exp_done(1)));
  endtask

  // One clock: check on the falling edge, advance the model on the rising edge.
  task automatic cyc(string tag);
    @(negedge clk);
    check_all(tag);
    busy_cnt8 += int'(busy8);
    done_cnt8 += int'(done8);
    done_cnt4 += int'(done4);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clr_stats();
    busy_cnt8 = 0; done_cnt8 = 0; done_cnt4 = 0;
  endtask

  task automatic start(int ld, bit md);
    go = 1; load = 8'(ld); mode = md;
    cyc("go");
    go = 0;
    load = 8'($urandom);
    mode = 1'($urandom);
    clr_stats();
  endtask

  initial begin
    rst_n = 0; go = 0; load = '0; mode = 0; hold = 0; abort = 0;
    model_reset();
    clr_stats();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    cyc("idle");

    // One-shot, load 5: six busy cycles, a single done pulse.
    start(5, 0);
    for (int k = 0; k < 9; k++) cyc("oneshot5");
    chk("oneshot5.busy_cycles", busy_cnt8, 6);
    chk("oneshot5.done_pulses", done_cnt8, 1);

    // Auto-restart, load 3: done every 4 cycles, then abort at count 2.
    start(3, 1);
    for (int k = 0; k < 12; k++) cyc("auto3");
    chk("auto3.done_pulses", done_cnt8, 3);
    cyc("auto3.c0");
    cyc("auto3.c1");
    chk("auto3.at2", int'(count8), 2);
    abort = 1;
    cyc("auto3.abort");
    abort = 0;
    cyc("auto3.after_abort");
    chk("auto3.idle_count", int'(count8), 0);

    // One-shot, load 4, hold for three cycles at count 2.
    start(4, 0);
    cyc("hold4"); cyc("hold4");
    hold = 1;
    for (int k = 0; k < 3; k++) cyc("hold4.held");
    hold = 0;
    for (int k = 0; k < 8; k++) cyc("hold4.resume");
    chk("hold4.busy_cycles", busy_cnt8, 9);
    chk("hold4.done_pulses", done_cnt8, 1);

    // Load 0: done in the first run cycle; with hold, done after resume.
    start(0, 0);
    cyc("zero.first");
    cyc("zero.idle");
    chk("zero.done_pulses", done_cnt8, 1);
    start(0, 0);
    hold = 1;
    cyc("zero.held");
    hold = 0;
    cyc("zero.pause");
    cyc("zero.resume");
    cyc("zero.idle2");
    chk("zero.held_done_pulses", done_cnt8, 1);

    // Full-scale 4-bit run, reset in the middle.
    start(15, 0);
    for (int k = 0; k < 9; k++) cyc("full4");
    chk("full4.at9", int'(count4), 9);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    cyc("post_reset");
    start(15, 0);
    for (int k = 0; k < 5; k++) cyc("full4b");
    go = 1; load = 8'd3; mode = 1;
    cyc("full4b.ignored_go");
    go = 0;
    for (int k = 0; k < 14; k++) cyc("full4b");
    chk("full4b.done_pulses", done_cnt4, 1);
    chk("full4b.idle", int'(busy4), 0);

    // Abort in IDLE blocks go.
    go = 1; abort = 1; load = 8'd7;
    cyc("idle_abort");
    go = 0; abort = 0;
    cyc("idle_abort.after");

    // Randomised traffic against the model.
    for (int k = 0; k < 600; k++) begin
      go    = ($urandom_range(0, 3) == 0);
      load  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      mode  = 1'($urandom);
      hold  = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 29) == 0);
      cyc("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
